// File: rtl/tetris_keys_pkg.sv
// Shared scan-code constants, key indices and parser state type for the Tetris key decoder.
package tetris_keys_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_RIGHT  = 8'h74;
  localparam logic [7:0] SC_ROTATE = 8'h75;
  localparam logic [7:0] SC_DOWN   = 8'h72;
  localparam logic [7:0] SC_SPACE  = 8'h29;

  localparam int NUM_KEYS = 5;

  typedef enum logic [2:0] {
    K_LEFT   = 3'd0,
    K_RIGHT  = 3'd1,
    K_ROTATE = 3'd2,
    K_DOWN   = 3'd3,
    K_HARD   = 3'd4
  } key_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } parse_state_t;

  // One-hot key mask for a completed code; all-zero means the code is not a game key.
  function automatic logic [NUM_KEYS-1:0] key_mask(input logic ext, input logic [7:0] code);
    logic [NUM_KEYS-1:0] m;
    m = '0;
    if (ext) begin
      case (code)
        SC_LEFT:   m[K_LEFT]   = 1'b1;
        SC_RIGHT:  m[K_RIGHT]  = 1'b1;
        SC_ROTATE: m[K_ROTATE] = 1'b1;
        SC_DOWN:   m[K_DOWN]   = 1'b1;
        default:   m = '0;
      endcase
    end else if (code == SC_SPACE) begin
      m[K_HARD] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/key_repeat_timer.sv
// Auto-repeat down-counter: load starts a REPEAT_DELAY interval, expire fires on terminal
// count and the counter reloads REPEAT_RATE; with run low the count is frozen.
module key_repeat_timer #(
  parameter int unsigned REPEAT_DELAY = 6_250_000,
  parameter int unsigned REPEAT_RATE  = 2_500_000,
  parameter int          CNT_W        = 24
) (
  input  logic iVGA_CLK,
  input  logic iRST_n,
  input  logic load,
  input  logic clr,
  input  logic run,
  output logic expire
);

  localparam logic [CNT_W-1:0] DELAY_V = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RATE_V  = CNT_W'(REPEAT_RATE);

  logic [CNT_W-1:0] cnt;

  // Terminal count is the step into zero, so the registered pulse lands exactly
  // REPEAT_DELAY / REPEAT_RATE cycles after the previous one.
  assign expire = run && !load && !clr && (cnt == CNT_W'(1));

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= DELAY_V;
    end else if (clr) begin
      cnt <= '0;
    end else if (run && cnt != '0) begin
      cnt <= (cnt == CNT_W'(1)) ? RATE_V : cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/tetris_key_decoder.sv
// PS/2 byte stream to single-cycle Tetris move pulses, with held-key tracking and
// locally generated auto-repeat for left, right and soft drop.
//   state      | meaning
//   ST_IDLE    | waiting for first byte of a code
//   ST_EXT     | E0 seen, extended code follows
//   ST_BRK     | F0 seen, non-extended break follows
//   ST_EXT_BRK | E0 F0 seen, extended break follows
module tetris_key_decoder
  import tetris_keys_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY = 6_250_000,
  parameter int unsigned REPEAT_RATE  = 2_500_000,
  parameter int          CNT_W        = 24
) (
  input  logic                iVGA_CLK,
  input  logic                iRST_n,
  input  logic                ps2_key_pressed,
  input  logic [7:0]          ps2_out,
  input  logic                enable,
  output logic                mv_left,
  output logic                mv_right,
  output logic                mv_rotate,
  output logic                mv_down,
  output logic                mv_hard,
  output logic [NUM_KEYS-1:0] held,
  output logic                code_err
);

  logic                ps2_q;
  logic                accept;
  parse_state_t        state;
  logic                ev_make, ev_brk, ev_ext, ev_unmapped;
  logic [NUM_KEYS-1:0] ev_mask, make_new, brk_held;
  logic                last_right;
  logic                frz_l, frz_r, res_l, res_r;
  logic [2:0]          t_load, t_clr, t_run, t_exp;

  assign accept = ps2_key_pressed & ~ps2_q;

  always_comb begin
    ev_make = 1'b0;
    ev_brk  = 1'b0;
    ev_ext  = 1'b0;
    if (accept) begin
      case (state)
        ST_IDLE:    ev_make = (ps2_out != SC_EXT) && (ps2_out != SC_BRK);
        ST_EXT: begin
          ev_make = (ps2_out != SC_EXT) && (ps2_out != SC_BRK);
          ev_ext  = 1'b1;
        end
        ST_BRK:     ev_brk = 1'b1;
        ST_EXT_BRK: begin
          ev_brk = 1'b1;
          ev_ext = 1'b1;
        end
        default:    ev_make = 1'b0;
      endcase
    end
  end

  assign ev_mask     = key_mask(ev_ext, ps2_out);
  assign make_new    = ev_make ? (ev_mask & ~held) : '0;
  assign brk_held    = ev_brk ? (ev_mask & held) : '0;
  assign ev_unmapped = (ev_make | ev_brk) && (ev_mask == '0);

  // Left/right lockout: only the newer of the two runs; a fresh press freezes the
  // other in the same cycle so the two can never pulse together.
  assign frz_l = make_new[K_RIGHT] | (held[K_RIGHT] & last_right);
  assign frz_r = make_new[K_LEFT]  | (held[K_LEFT]  & ~last_right);
  assign res_l = brk_held[K_RIGHT] & held[K_LEFT]  & last_right;
  assign res_r = brk_held[K_LEFT]  & held[K_RIGHT] & ~last_right;

  assign t_load[0] = make_new[K_LEFT]  | res_l | (~enable & held[K_LEFT]  & ~brk_held[K_LEFT]);
  assign t_load[1] = make_new[K_RIGHT] | res_r | (~enable & held[K_RIGHT] & ~brk_held[K_RIGHT]);
  assign t_load[2] = make_new[K_DOWN]  | (~enable & held[K_DOWN] & ~brk_held[K_DOWN]);
  assign t_clr     = {brk_held[K_DOWN], brk_held[K_RIGHT], brk_held[K_LEFT]};
  assign t_run[0]  = held[K_LEFT]  & enable & ~frz_l;
  assign t_run[1]  = held[K_RIGHT] & enable & ~frz_r;
  assign t_run[2]  = held[K_DOWN]  & enable;

  key_repeat_timer #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE), .CNT_W(CNT_W)) u_tmr_left (
    .iVGA_CLK(iVGA_CLK), .iRST_n(iRST_n), .load(t_load[0]), .clr(t_clr[0]), .run(t_run[0]), .expire(t_exp[0])
  );
  key_repeat_timer #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE), .CNT_W(CNT_W)) u_tmr_right (
    .iVGA_CLK(iVGA_CLK), .iRST_n(iRST_n), .load(t_load[1]), .clr(t_clr[1]), .run(t_run[1]), .expire(t_exp[1])
  );
  key_repeat_timer #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE), .CNT_W(CNT_W)) u_tmr_down (
    .iVGA_CLK(iVGA_CLK), .iRST_n(iRST_n), .load(t_load[2]), .clr(t_clr[2]), .run(t_run[2]), .expire(t_exp[2])
  );

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      ps2_q      <= 1'b0;
      state      <= ST_IDLE;
      held       <= '0;
      last_right <= 1'b0;
      mv_left    <= 1'b0;
      mv_right   <= 1'b0;
      mv_rotate  <= 1'b0;
      mv_down    <= 1'b0;
      mv_hard    <= 1'b0;
      code_err   <= 1'b0;
    end else begin
      ps2_q <= ps2_key_pressed;
      if (accept) begin
        case (state)
          ST_IDLE: state <= (ps2_out == SC_EXT) ? ST_EXT :
                            (ps2_out == SC_BRK) ? ST_BRK : ST_IDLE;
          ST_EXT:  state <= (ps2_out == SC_BRK) ? ST_EXT_BRK :
                            (ps2_out == SC_EXT) ? ST_EXT : ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
      held <= (held & ~brk_held) | make_new;
      if (make_new[K_RIGHT]) begin
        last_right <= 1'b1;
      end else if (make_new[K_LEFT]) begin
        last_right <= 1'b0;
      end
      mv_left   <= enable & (make_new[K_LEFT]  | t_exp[0]);
      mv_right  <= enable & (make_new[K_RIGHT] | t_exp[1]);
      mv_down   <= enable & (make_new[K_DOWN]  | t_exp[2]);
      mv_rotate <= enable & make_new[K_ROTATE];
      mv_hard   <= enable & make_new[K_HARD];
      code_err  <= ev_unmapped;
    end
  end

endmodule

// File: tb/tb_tetris_key_decoder.sv
// Scoreboard bench for tetris_key_decoder: a cycle-level key model predicts pulses,
// a monitor compares them against the DUT outputs each cycle something happens.
module tb_tetris_key_decoder;

  localparam int D = 10;
  localparam int R = 4;

  logic       iVGA_CLK = 1'b0;
  logic       iRST_n = 1'b0;
  logic       ps2_key_pressed = 1'b0;
  logic [7:0] ps2_out = 8'h00;
  logic       enable = 1'b1;
  logic       mv_left, mv_right, mv_rotate, mv_down, mv_hard, code_err;
  logic [4:0] held;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic en_req = 1'b1;

  typedef struct { int cyc; int key; } exp_t;
  exp_t sb[$];

  bit         m_held[5];
  int         due[5];
  int         newest;
  logic [7:0] pend[$];
  bit         prev_kp, prev_en;
  logic [7:0] codes[6] = '{8'h6B, 8'h74, 8'h75, 8'h72, 8'h29, 8'h1C};

  tetris_key_decoder #(.REPEAT_DELAY(D), .REPEAT_RATE(R), .CNT_W(8)) dut (
    .iVGA_CLK(iVGA_CLK), .iRST_n(iRST_n), .ps2_key_pressed(ps2_key_pressed),
    .ps2_out(ps2_out), .enable(enable), .mv_left(mv_left), .mv_right(mv_right),
    .mv_rotate(mv_rotate), .mv_down(mv_down), .mv_hard(mv_hard), .held(held),
    .code_err(code_err)
  );

  always #5 iVGA_CLK = ~iVGA_CLK;
  always @(posedge iVGA_CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (cyc %0d)", nm, got, want, cyc);
    end
  endtask

  task automatic push(input int c, input int k);
    exp_t e;
    e.cyc = c;
    e.key = k;
    sb.push_back(e);
  endtask

  function automatic int lookup(input bit ext, input logic [7:0] b);
    int k;
    k = -1;
    if (ext) begin
      if (b == 8'h6B) k = 0;
      else if (b == 8'h74) k = 1;
      else if (b == 8'h75) k = 2;
      else if (b == 8'h72) k = 3;
    end else if (b == 8'h29) begin
      k = 4;
    end
    return k;
  endfunction

  function automatic logic [4:0] held_vec();
    logic [4:0] v;
    for (int i = 0; i < 5; i++) v[i] = m_held[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      m_held[i] = 1'b0;
      due[i] = -1;
    end
    pend.delete();
    prev_kp = 1'b0;
    prev_en = 1'b1;
    newest = 0;
  endtask

  // One completed byte, arriving at cycle c; its effects show from cycle c+1.
  task automatic accept_byte(input logic [7:0] b, input int c);
    bit has_e0, has_f0;
    int k;
    has_e0 = 1'b0;
    has_f0 = 1'b0;
    foreach (pend[i]) begin
      if (pend[i] == 8'hE0) has_e0 = 1'b1;
      if (pend[i] == 8'hF0) has_f0 = 1'b1;
    end
    if (!has_f0 && (b == 8'hE0 || b == 8'hF0)) begin
      pend.push_back(b);
      return;
    end
    pend.delete();
    k = lookup(has_e0, b);
    if (k < 0) begin
      push(c + 1, 5);
    end else if (!has_f0) begin
      if (!m_held[k]) begin
        m_held[k] = 1'b1;
        if (enable) push(c + 1, k);
        if (k == 0 || k == 1) begin
          newest = k;
          due[k] = enable ? c + 1 + D : -1;
          due[1 - k] = -1;
        end else if (k == 3) begin
          due[3] = enable ? c + 1 + D : -1;
        end
      end
    end else if (m_held[k]) begin
      m_held[k] = 1'b0;
      due[k] = -1;
      if ((k == 0 || k == 1) && m_held[1 - k] && newest == k && enable)
        due[1 - k] = c + 1 + D;
    end
  endtask

  task automatic model_eval();
    int c;
    c = cyc;
    if (!enable) begin
      for (int i = 0; i < 5; i++) due[i] = -1;
    end else if (!prev_en) begin
      if (m_held[3]) due[3] = c + D;
      if (m_held[0] && (!m_held[1] || newest == 0)) due[0] = c + D;
      if (m_held[1] && (!m_held[0] || newest == 1)) due[1] = c + D;
    end
    if (ps2_key_pressed && !prev_kp) accept_byte(ps2_out, c);
    for (int k = 0; k < 4; k++) begin
      if (k != 2 && enable && due[k] == c + 1) begin
        push(c + 1, k);
        due[k] += R;
      end
    end
    prev_kp = ps2_key_pressed;
    prev_en = enable;
  endtask

  task automatic drive(input logic kp, input logic [7:0] b);
    @(negedge iVGA_CLK);
    ps2_key_pressed = kp;
    ps2_out = b;
    enable = en_req;
    model_eval();
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00);
  endtask

  task automatic send(input logic [7:0] b, input int hold, input int gap);
    repeat (hold) drive(1'b1, b);
    repeat (gap) drive(1'b0, b);
  endtask

  task automatic key_seq(input bit ext, input bit brk, input logic [7:0] code, input int hold, input int gap);
    if (ext) send(8'hE0, hold, gap);
    if (brk) send(8'hF0, hold, gap);
    send(code, hold, gap);
  endtask

  task automatic check_held(input string nm);
    idle(1);
    chk(nm, 32'(held), 32'(held_vec()));
  endtask

  task automatic do_reset();
    @(negedge iVGA_CLK);
    iRST_n = 1'b0;
    ps2_key_pressed = 1'b0;
    model_reset();
    sb.delete();
    repeat (2) @(negedge iVGA_CLK);
    chk("rst_pulses", 32'({code_err, mv_hard, mv_down, mv_rotate, mv_right, mv_left}), 32'd0);
    chk("rst_held", 32'(held), 32'd0);
    iRST_n = 1'b1;
  endtask

  // Monitor: whenever the DUT pulses or a pulse is expected this cycle, compare.
  initial begin
    logic [5:0] act_v, exp_v;
    bit missed;
    exp_t e;
    forever begin
      @(negedge iVGA_CLK);
      if (iRST_n) begin
        exp_v = '0;
        missed = 1'b0;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
          e = sb.pop_front();
          if (e.cyc < cyc) missed = 1'b1;
          else exp_v[e.key] = 1'b1;
        end
        act_v = {code_err, mv_hard, mv_down, mv_rotate, mv_right, mv_left};
        if (act_v != '0 || exp_v != '0 || missed) begin
          total++;
          if (act_v != exp_v || missed) begin
            bad++;
            $display("FAIL pulses cyc=%0d got=%b want=%b stale=%0d", cyc, act_v, exp_v, missed);
          end
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    bit ext, brk;
    int ci;
    do_reset();
    idle(3);

    // press / release left
    key_seq(1, 0, 8'h6B, 1, 2);
    check_held("held_left_make");
    idle(15);
    key_seq(1, 1, 8'h6B, 1, 2);
    check_held("held_left_brk");
    idle(25);

    // right held with typematic bytes; break lands just after the t0+18 repeat
    key_seq(1, 0, 8'h74, 1, 2);
    idle(3);
    key_seq(1, 0, 8'h74, 1, 2);
    idle(1);
    key_seq(1, 1, 8'h74, 1, 2);
    check_held("held_right_brk");
    idle(20);

    // down released exactly when its first repeat would expire
    key_seq(1, 0, 8'h72, 1, 2);
    idle(1);
    key_seq(1, 1, 8'h72, 1, 2);
    idle(20);

    // lockout
    key_seq(1, 0, 8'h6B, 1, 2);
    idle(12);
    key_seq(1, 0, 8'h74, 1, 2);
    check_held("held_both");
    idle(20);
    key_seq(1, 1, 8'h74, 1, 2);
    idle(25);
    key_seq(1, 1, 8'h6B, 1, 2);
    idle(10);

    // space held high for 5 cycles
    send(8'h29, 5, 2);
    idle(30);
    check_held("held_space");
    key_seq(0, 1, 8'h29, 1, 2);
    idle(5);

    // unmapped codes and a pause sequence
    send(8'h6B, 1, 2);
    send(8'hE1, 1, 2); send(8'h14, 1, 2); send(8'h77, 1, 2);
    send(8'hE1, 1, 2); send(8'hF0, 1, 2); send(8'h14, 1, 2);
    send(8'hF0, 1, 2); send(8'h77, 1, 2);
    check_held("held_after_err");

    // reset after a lone E0
    send(8'hE0, 1, 2);
    idle(2);
    do_reset();
    idle(2);
    send(8'h75, 1, 2);
    check_held("held_after_rst");
    idle(5);

    // make while disabled, then enable
    en_req = 1'b0;
    idle(2);
    key_seq(1, 0, 8'h72, 1, 2);
    check_held("held_down_dis");
    idle(20);
    en_req = 1'b1;
    idle(D + 8);
    key_seq(1, 1, 8'h72, 1, 2);
    idle(5);

    // randomized traffic
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 99) < 5) en_req = ~en_req;
      ext = ($urandom_range(0, 3) != 0);
      brk = ($urandom_range(0, 2) == 0);
      ci  = $urandom_range(0, 5);
      if ($urandom_range(0, 19) == 0) send(8'hE0, 1, 1);
      key_seq(ext, brk, codes[ci], $urandom_range(1, 4), $urandom_range(1, 6));
      idle($urandom_range(0, 25));
      if (i % 25 == 24) check_held("held_rand");
    end

    en_req = 1'b1;
    idle(3);
    for (int k = 0; k < 5; k++) begin
      if (m_held[k]) key_seq(k != 4, 1'b1, codes[k], 1, 2);
    end
    check_held("held_final");
    idle(20);
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
